// File: rtl/pdmafifo_sync_ctrl_if.sv
// Bundle between the FIFO controller, its writer/reader and the external dual-port RAM.
// The slave modport is the controller's view; master is the environment driving it.
interface pdmafifo_sync_ctrl_if #(
   parameter int WIDTH = 18,
   parameter int ADDRW = 10
);
   logic             we;
   logic [WIDTH-1:0] din;
   logic             re;
   logic             full;
   logic             afull;
   logic             empty;
   logic             aempty;
   logic             wr_ack;
   logic             overflow;
   logic             underflow;
   logic             rd_dvld;
   logic [ADDRW:0]   count;
   logic             MEMWE;
   logic [ADDRW-1:0] MEMWADDR;
   logic [WIDTH-1:0] MEMWD;
   logic             MEMRE;
   logic [ADDRW-1:0] MEMRADDR;
   logic [WIDTH-1:0] MEMRD;
   logic [WIDTH-1:0] dout;

   modport master (
      output we, din, re, MEMRD,
      input  full, afull, empty, aempty, wr_ack, overflow, underflow, rd_dvld,
      input  count, MEMWE, MEMWADDR, MEMWD, MEMRE, MEMRADDR, dout
   );

   modport slave (
      input  we, din, re, MEMRD,
      output full, afull, empty, aempty, wr_ack, overflow, underflow, rd_dvld,
      output count, MEMWE, MEMWADDR, MEMWD, MEMRE, MEMRADDR, dout
   );
endinterface

// File: rtl/pdmafifo_sync_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count and registered status flags
// for an external 1-cycle-latency dual-port RAM feeding the FWFT output stage.
module pdmafifo_sync_ctrl #(
   parameter int WIDTH      = 18,
   parameter int DEPTH      = 1024,
   parameter int ADDRW      = 10,
   parameter int AFULL_VAL  = 1020,
   parameter int AEMPTY_VAL = 4
) (
   input logic                 clk,
   input logic                 rst,
   pdmafifo_sync_ctrl_if.slave bus
);
   localparam int CW = ADDRW + 1;
   localparam logic [ADDRW:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [ADDRW:0] AFULL_C  = CW'(AFULL_VAL);
   localparam logic [ADDRW:0] AEMPTY_C = CW'(AEMPTY_VAL);

   logic [ADDRW:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDRW:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDRW:0]   count_q, count_d;
   logic             full_q, full_d;
   logic             afull_q, afull_d;
   logic             empty_q, empty_d;
   logic             aempty_q, aempty_d;
   logic             wr_ack_q, wr_ack_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             rd_dvld_q, rd_dvld_d;
   logic             wa;
   logic             ra;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] rd_data;

   // Accepts use only registered flags, so no path exists from we/re to any flag.
   always_comb begin
      wa          = bus.we & ~full_q;
      ra          = bus.re & ~empty_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (wa) wr_ptr_d = wr_ptr_q + CW'(1);
      if (ra) rd_ptr_d = rd_ptr_q + CW'(1);
      case ({wa, ra})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d      = (count_d == DEPTH_C);
      empty_d     = (count_d == '0);
      afull_d     = (count_d >= AFULL_C);
      aempty_d    = (count_d <= AEMPTY_C);
      wr_ack_d    = wa;
      overflow_d  = bus.we & full_q;
      underflow_d = bus.re & empty_q;
      rd_dvld_d   = ra;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         afull_q     <= 1'b0;
         empty_q     <= 1'b1;
         aempty_q    <= 1'b1;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_dvld_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         afull_q     <= afull_d;
         empty_q     <= empty_d;
         aempty_q    <= aempty_d;
         wr_ack_q    <= wr_ack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rd_dvld_q   <= rd_dvld_d;
      end
   end

   // The RAM registers its read data, so MEMRD lines up with rd_dvld without extra staging.
   assign wr_data       = bus.din;
   assign rd_data       = bus.MEMRD;
   assign bus.MEMWE     = wa;
   assign bus.MEMWD     = wr_data;
   assign bus.MEMWADDR  = wr_ptr_q[ADDRW-1:0];
   assign bus.MEMRE     = ra;
   assign bus.MEMRADDR  = rd_ptr_q[ADDRW-1:0];
   assign bus.dout      = rd_data;
   assign bus.count     = count_q;
   assign bus.full      = full_q;
   assign bus.afull     = afull_q;
   assign bus.empty     = empty_q;
   assign bus.aempty    = aempty_q;
   assign bus.wr_ack    = wr_ack_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
   assign bus.rd_dvld   = rd_dvld_q;
endmodule

// File: tb/tb_pdmafifo_sync_ctrl.sv
// Directed bench for pdmafifo_sync_ctrl with a behavioural RAM and a queue-based reference.
module tb_pdmafifo_sync_ctrl;
   localparam int WIDTH  = 18;
   localparam int DEPTH  = 1024;
   localparam int ADDRW  = 10;
   localparam int AFULL  = 1020;
   localparam int AEMPTY = 4;

   logic clk;
   logic rst_n;

   pdmafifo_sync_ctrl_if #(.WIDTH(WIDTH), .ADDRW(ADDRW)) bus ();

   pdmafifo_sync_ctrl #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRW(ADDRW),
      .AFULL_VAL(AFULL), .AEMPTY_VAL(AEMPTY)
   ) dut (
      .clk(clk),
      .rst(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural dual-port RAM with registered read data.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] ram_rd;
   always @(posedge clk) begin
      if (bus.MEMWE) mem[bus.MEMWADDR] <= bus.MEMWD;
      if (bus.MEMRE) ram_rd <= mem[bus.MEMRADDR];
   end
   assign bus.MEMRD = ram_rd;

   int checks;
   int errors;
   int mcount;
   int mwptr;
   int mrptr;
   logic [WIDTH-1:0] mq [$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] flagVec();
      return 32'({bus.full, bus.afull, bus.empty, bus.aempty,
                  bus.wr_ack, bus.overflow, bus.underflow, bus.rd_dvld});
   endfunction

   // One clock of stimulus; checks RAM controls before the edge and all outputs after it.
   task automatic applyStimulus(input logic w, input logic r, input logic [WIDTH-1:0] d);
      logic pre_full, pre_empty, wa, ra;
      logic [WIDTH-1:0] exp_word;
      logic [7:0] ef;
      pre_full  = (mcount == DEPTH);
      pre_empty = (mcount == 0);
      wa = w && !pre_full;
      ra = r && !pre_empty;
      exp_word = '0;
      bus.we  = w;
      bus.re  = r;
      bus.din = d;
      #1;
      checkOutput("memctl", 32'({bus.MEMWE, bus.MEMRE, bus.MEMWADDR, bus.MEMRADDR}),
                  32'({wa, ra, ADDRW'(mwptr), ADDRW'(mrptr)}));
      checkOutput("memwd", 32'(bus.MEMWD), 32'(d));
      @(posedge clk);
      #1;
      if (ra) exp_word = mq.pop_front();
      if (wa) mq.push_back(d);
      if (wa) mwptr = (mwptr + 1) % DEPTH;
      if (ra) mrptr = (mrptr + 1) % DEPTH;
      mcount = mcount + int'(wa) - int'(ra);
      ef = {mcount == DEPTH, mcount >= AFULL, mcount == 0, mcount <= AEMPTY,
            wa, w && pre_full, r && pre_empty, ra};
      checkOutput("count", 32'(bus.count), 32'(mcount));
      checkOutput("flags", flagVec(), 32'(ef));
      if (ra) checkOutput("dout", 32'(bus.dout), 32'(exp_word));
   endtask

   task automatic modelReset();
      mcount = 0;
      mwptr  = 0;
      mrptr  = 0;
      mq.delete();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks  = 0;
      errors  = 0;
      modelReset();
      rst_n   = 1'b0;
      bus.we  = 1'b0;
      bus.re  = 1'b0;
      bus.din = '0;
      #23;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      $display("[TB] reset and idle");
      checkOutput("reset_flags", flagVec(), 32'h30);
      checkOutput("reset_count", 32'(bus.count), 32'd0);
      repeat (3) applyStimulus(1'b0, 1'b0, '0);

      $display("[TB] five writes then five reads");
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 1'b0, WIDTH'(i));
         if (i == 4) checkOutput("aempty_at4", 32'(bus.aempty), 32'd1);
      end
      checkOutput("count5", 32'(bus.count), 32'd5);
      checkOutput("aempty_at5", 32'(bus.aempty), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b0, 1'b1, '0);
         checkOutput("dout_seq", 32'(bus.dout), 32'(i));
         if (i == 1) checkOutput("aempty_back4", 32'(bus.aempty), 32'd1);
      end
      checkOutput("empty_again", 32'(bus.empty), 32'd1);

      $display("[TB] fill to full");
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b0, WIDTH'(i + 256));
         if (i == AFULL - 2) checkOutput("afull_1019", 32'(bus.afull), 32'd0);
         if (i == AFULL - 1) checkOutput("afull_1020", 32'(bus.afull), 32'd1);
      end
      checkOutput("full_set", 32'({bus.full, bus.afull}), 32'h3);
      checkOutput("count_full", 32'(bus.count), 32'd1024);
      applyStimulus(1'b1, 1'b0, WIDTH'(18'h3FFFF));
      checkOutput("overflow", 32'({bus.overflow, bus.wr_ack}), 32'h2);
      checkOutput("count_ovf", 32'(bus.count), 32'd1024);
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("overflow_pulse", 32'(bus.overflow), 32'd0);

      $display("[TB] read and write together at full");
      applyStimulus(1'b1, 1'b1, WIDTH'(18'h2AAAA));
      checkOutput("full_rw_count", 32'(bus.count), 32'd1023);
      checkOutput("full_rw_flags", 32'({bus.full, bus.overflow, bus.rd_dvld}), 32'h3);

      $display("[TB] drain and read/write together at empty");
      for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, 1'b1, '0);
      checkOutput("drained", 32'(bus.empty), 32'd1);
      applyStimulus(1'b1, 1'b1, WIDTH'(18'h15555));
      checkOutput("empty_rw", 32'({bus.underflow, bus.wr_ack, bus.empty, bus.rd_dvld}), 32'hC);
      checkOutput("empty_rw_count", 32'(bus.count), 32'd1);

      $display("[TB] streaming with a mid-stream reset");
      applyStimulus(1'b1, 1'b0, WIDTH'(18'h00777));
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            rst_n = 1'b0;
            #1;
            checkOutput("async_rst_flags", flagVec(), 32'h30);
            checkOutput("async_rst_count", 32'(bus.count), 32'd0);
            bus.we = 1'b0;
            bus.re = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            modelReset();
            checkOutput("post_rst_flags", flagVec(), 32'h30);
            checkOutput("post_rst_waddr", 32'(bus.MEMWADDR), 32'd0);
            applyStimulus(1'b1, 1'b0, WIDTH'(18'h01111));
            applyStimulus(1'b1, 1'b0, WIDTH'(18'h02222));
         end
         applyStimulus(1'b1, 1'b1, WIDTH'(i + 20000));
      end
      checkOutput("stream_count", 32'(bus.count), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pdmafifo_sync_ctrl.md
Name: pdmafifo_sync_ctrl

Overview:
Single-clock FIFO controller that sits directly upstream of the FWFT output stage. It owns the write/read pointers, the occupancy count and the status flags. It drives the external dual-port RAM's write and read ports. It supplies fifo_empty, fifo_aempty, fifo_dout and fifo_MEMRADDR to the FWFT stage and accepts that stage's fifo_rd_en.

Parameters:
WIDTH, 18, data width of write and read ports
DEPTH, 1024, number of RAM words; power of two, 4..65536
ADDRW, 10, log2(DEPTH); RAM address width
AFULL_VAL, 1020, afull asserted when count >= AFULL_VAL; range 1..DEPTH-1
AEMPTY_VAL, 4, aempty asserted when count <= AEMPTY_VAL; range 0..DEPTH-2

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous active-low reset
we  in  1  write request, active high
din  in  WIDTH  write data
re  in  1  read request, active high (fifo_rd_en from the FWFT stage)
full  out  1  FIFO full
afull  out  1  almost full
empty  out  1  FIFO empty (fifo_empty to the FWFT stage)
aempty  out  1  almost empty (fifo_aempty to the FWFT stage)
wr_ack  out  1  previous-cycle write accepted
overflow  out  1  previous-cycle write rejected because FIFO was full
underflow  out  1  previous-cycle read rejected because FIFO was empty
rd_dvld  out  1  dout valid; registered one cycle after an accepted read
count  out  ADDRW+1  occupancy, 0..DEPTH
MEMWE  out  1  RAM write enable
MEMWADDR  out  ADDRW  RAM write address
MEMWD  out  WIDTH  RAM write data (equals din)
MEMRE  out  1  RAM read enable
MEMRADDR  out  ADDRW  RAM read address (fifo_MEMRADDR to the FWFT stage)
MEMRD  in  WIDTH  RAM read data, registered in RAM with 1-cycle latency
dout  out  WIDTH  read data (equals MEMRD; fifo_dout to the FWFT stage)

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Outputs: empty=1, aempty=1, full=0, afull=0, wr_ack=0, overflow=0, underflow=0, rd_dvld=0.
- Reset mid-operation discards all contents; the pointers restart at address 0.
- Pointers are ADDRW+1 bits wide. MEMWADDR=wr_ptr[ADDRW-1:0] and MEMRADDR=rd_ptr[ADDRW-1:0], both combinational from the registers.
- Pointers wrap naturally at 2^(ADDRW+1).
- Write accept: wa = we & !full. Read accept: ra = re & !empty. Both are evaluated on current registered flags.
- MEMWE=wa, MEMWD=din, MEMRE=ra. These are combinational.
- On wa, wr_ptr increments by 1. On ra, rd_ptr increments by 1.
- count_next = count + wa - ra. Both at once leaves count unchanged.
- Flags are registered from count_next, with no combinational path from we/re to the flags:
  - full <= (count_next == DEPTH)
  - empty <= (count_next == 0)
  - afull <= (count_next >= AFULL_VAL)
  - aempty <= (count_next <= AEMPTY_VAL)
- Simultaneous we&re when full: read accepted, write rejected, overflow=1 next cycle; count becomes DEPTH-1.
- Simultaneous we&re when empty: write accepted, read rejected, underflow=1 next cycle; count becomes 1.
- First-write latency: the write in cycle N clears empty at edge N+1. The earliest read is cycle N+1, with data at dout in cycle N+2.
- Read latency: ra in cycle N gives rd_dvld=1 and dout=word in cycle N+1.
- Registered pulses: wr_ack <= wa, overflow <= we & full, underflow <= re & empty, rd_dvld <= ra. Each is one cycle per event.
- Back-to-back reads and writes sustain 1 word/cycle each, indefinitely.

Test Plan:
- Reset then idle -> empty=1, aempty=1, full=0, count=0, no MEMWE/MEMRE pulses.
- Write 0x00001..0x00005 on consecutive cycles, then read 5 -> dout 0x00001..0x00005 in order, each one cycle after MEMRE. Empty reasserts after the 5th read; aempty deasserts at count=5 and reasserts at count=4.
- Fill to DEPTH=1024 -> full=1 and afull=1 (afull from count 1020). A further write gives overflow=1 for one cycle and count stays 1024.
- At full, we=re=1 for one cycle -> read accepted, overflow=1, count=1023, full=0.
- At empty, we=re=1 -> underflow=1, wr_ack=1, count=1, empty=0 next cycle, rd_dvld=0.
- Stream 3000 words with we=re=1 continuously from count=2 -> pointer wrap is seamless, data in order, count stays 2. Assert rst=0 mid-stream -> all flags return to reset values immediately (asynchronously).
